move_pulse_gen: RTL and testbench
=================================

# move_pulse_gen

Front-end for the frog position tracker: turns four raw, asynchronous direction keys into the one-cycle L/R/U/D move strobes that the position counter consumes. Each key is synchronized and edge-qualified, so a press yields exactly one move. If the key is held, the block auto-repeats after a hold delay. Outputs are registered and mutually exclusive. They use the same L > R > U > D priority as the position counter, so one strobe moves the frog one step.

## Interface
- HOLD_DELAY, 8: cycles from the initial move pulse to the first auto-repeat pulse; legal range ≥ 2.
- REPEAT_PERIOD, 4: cycles between successive auto-repeat pulses; legal range ≥ 2.
- clock  in  1  system clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-low (asserted when 0).
- enable  in  1  synchronous gate; 0 disarms the block.
- key_l, key_r, key_u, key_d  in  1 each  raw, asynchronous key levels, 1 = pressed.
- L, R, U, D  out  1 each  registered move strobes; at most one is high in any cycle.
- busy  out  1  registered; 1 while a key is latched (state HOLD or REPEAT).

## Operation
- Synchronizer: each key passes through 2 flops (s1, s2). The FSM reads only s2.
- Internal state: FSM state, latched direction dir (2 bits), and counter cnt. cnt is sized to hold max(HOLD_DELAY, REPEAT_PERIOD)−1.
- Registered outputs: every cycle, all strobes default to 0. A strobe is 1 only in the cycle after the edge on which a transition below says "pulse".
- IDLE:
  - If any s2 key is 1 and enable=1: pick by priority L > R > U > D, latch it into dir, pulse that strobe, clear cnt, go to HOLD.
  - Otherwise stay in IDLE.
- HOLD:
  - If the s2 key for dir is 0: go to IDLE with no pulse.
  - Else if cnt == HOLD_DELAY−1: pulse dir, clear cnt, go to REPEAT.
  - Else: increment cnt.
- REPEAT:
  - If the s2 key for dir is 0: go to IDLE with no pulse.
  - Else if cnt == REPEAT_PERIOD−1: pulse dir and clear cnt.
  - Else: increment cnt.
- Other keys are ignored while in HOLD or REPEAT. Pressing or releasing a non-latched key has no effect.
- Key release rule:
  - When the latched key is released and another key is still held, the FSM returns to IDLE first.
  - On the next edge, the still-held key is treated as a new press: one pulse, then its own hold delay.
- enable=0: on the next edge, the FSM goes to IDLE, cnt clears, no strobes, busy=0. Synchronizers keep running.
- enable rising while a key is held: that key is treated as a new press on the first edge with enable=1.
- Simultaneous press of several keys in the same cycle: only the highest-priority key produces a pulse and is latched.
- busy = 1 exactly when the registered state is HOLD or REPEAT.

## Timing
- Reset (RST=0) takes effect immediately, independent of clock. It forces:
  - s1 and s2 to 0;
  - state to IDLE, cnt to 0, dir to L (encoding 0);
  - L, R, U, D and busy to 0.
- Reset asserted mid-hold or mid-pulse: the strobe drops at once. After RST releases, a key that is still held is a fresh press, first pulse after 3 edges.
- Press latency: the key is stable high before edge N. Sync flops load at edges N and N+1. The strobe is high between edge N+2 and edge N+3.
- Auto-repeat, with the initial strobe registered at edge P:
  - first repeat strobe registered at edge P+HOLD_DELAY;
  - subsequent strobes at P+HOLD_DELAY+k·REPEAT_PERIOD for k = 1, 2, ….
- Release latency: the key goes low before edge M. The FSM sees it at M+2 and enters IDLE at M+2. No strobe is registered at or after M+2.
- A strobe may be registered at M or M+1, if that edge coincides with a repeat boundary.
- Minimum strobe separation is 2 cycles, so the position counter never sees a back-to-back pulse.

## Test plan
- Reset and single tap: RST=0 → all outputs 0. Release RST, raise key_l for 3 cycles, then drop it → L high for exactly 1 cycle, 3 edges after the press; R/U/D stay 0; busy returns to 0.
- Hold auto-repeat (defaults): hold key_u for 30 cycles → U strobes at edges P, P+8, P+12, P+16, P+20, P+24, P+28 (7 total). No strobe after release propagates.
- Priority: raise key_d and key_r in the same cycle and hold both → only R pulses and repeats. Drop key_r → busy falls, D pulses one edge later, then D repeats after 8 more cycles.
- Enable gating: hold key_l with enable=0 for 10 cycles → no strobes, busy=0. Raise enable → L pulses on the first edge with enable=1. Drop enable mid-REPEAT → strobes stop, busy=0 on the next edge.
- Async reset mid-operation: while in REPEAT, pulse RST low between clock edges → L and busy drop immediately, without a clock edge. After release with the key still held → a new press pulse appears 3 edges later, followed by a full 8-cycle hold delay.
- Exclusivity sweep: random key patterns for 2000 cycles → the assertion that at most one strobe is high holds every cycle. The strobe count equals the reference-model count derived from the FSM rules above.

Source files
------------

// File: rtl/move_pulse_gen.sv
// move_pulse_gen
//   Converts four raw, asynchronous direction keys into registered,
//   mutually exclusive one-cycle move strobes for the position counter.
//   A press gives one strobe. A held key auto-repeats: the first repeat
//   comes HOLD_DELAY cycles after the press strobe, and later repeats
//   come every REPEAT_PERIOD cycles after that.
//   Simultaneous keys resolve by L > R > U > D priority.
//
// Ports
//   clock                      system clock, rising edge
//   RST                        asynchronous reset, active low
//   enable                     synchronous gate; 0 returns the block to idle
//   key_l, key_r, key_u, key_d raw key levels, 1 = pressed
//   L, R, U, D                 registered move strobes, at most one high
//   busy                       registered; 1 while a direction is latched
module move_pulse_gen #(
    parameter int unsigned HOLD_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic clock,
    input  logic RST,
    input  logic enable,
    input  logic key_l,
    input  logic key_r,
    input  logic key_u,
    input  logic key_d,
    output logic L,
    output logic R,
    output logic U,
    output logic D,
    output logic busy
);

    localparam int unsigned CNT_MAX =
        ((HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD) - 1;
    localparam int unsigned CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    // Key vectors and the direction code share one bit order: 0=L 1=R 2=U 3=D
    logic [3:0]    s1_q, s2_q;
    state_t        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    strb_q, strb_d;
    logic          busy_q;
    logic [1:0]    pick;
    logic          dir_held;

    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= ST_IDLE;
            dir_q   <= '0;
            cnt_q   <= '0;
            strb_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= {key_d, key_u, key_r, key_l};
            s2_q    <= s1_q;
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            // Registered copy of "state is HOLD or REPEAT"
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Highest-priority synchronized key
    always_comb begin
        pick = 2'd0;
        if (s2_q[0]) begin
            pick = 2'd0;
        end else if (s2_q[1]) begin
            pick = 2'd1;
        end else if (s2_q[2]) begin
            pick = 2'd2;
        end else if (s2_q[3]) begin
            pick = 2'd3;
        end
    end

    assign dir_held = s2_q[dir_q];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        strb_d  = '0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|s2_q) begin
                        dir_d        = pick;
                        strb_d[pick] = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!dir_held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        strb_d[dir_q] = 1'b1;
                        cnt_d         = '0;
                        state_d       = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!dir_held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REP_LAST) begin
                        strb_d[dir_q] = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign L    = strb_q[0];
    assign R    = strb_q[1];
    assign U    = strb_q[2];
    assign D    = strb_q[3];
    assign busy = busy_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
module tb_move_pulse_gen;

    localparam int HD = 8;
    localparam int RP = 4;

    logic       clock = 1'b0;
    logic       RST   = 1'b1;
    logic       enable;
    logic [3:0] keys;          // bit order: 0=L 1=R 2=U 3=D
    logic       L, R, U, D, busy;
    logic [3:0] strb;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    assign strb = {D, U, R, L};

    move_pulse_gen #(
        .HOLD_DELAY   (HD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock (clock),
        .RST   (RST),
        .enable(enable),
        .key_l (keys[0]),
        .key_r (keys[1]),
        .key_u (keys[2]),
        .key_d (keys[3]),
        .L     (L),
        .R     (R),
        .U     (U),
        .D     (D),
        .busy  (busy)
    );

    // Reference model: two-edge key delay, latched key index and its age in
    // cycles since its press strobe. Strobes fire at age 0 and at
    // age = HD + k*RP.
    logic [3:0] m_p1, m_p2;
    int         m_lat;
    int         m_age;
    logic [3:0] m_strb;
    logic       m_busy;

    task automatic model_reset();
        m_p1   = '0;
        m_p2   = '0;
        m_lat  = -1;
        m_age  = 0;
        m_strb = '0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        seen   = m_p2;
        m_p2   = m_p1;
        m_p1   = keys;
        m_strb = '0;
        if (!enable) begin
            m_lat = -1;
        end else if (m_lat < 0) begin
            if (seen != 4'b0) begin
                for (int i = 3; i >= 0; i--) if (seen[i]) m_lat = i;
                m_age = 0;
                m_strb[m_lat] = 1'b1;
            end
        end else if (!seen[m_lat]) begin
            m_lat = -1;
        end else begin
            m_age++;
            if (m_age >= HD && ((m_age - HD) % RP) == 0) m_strb[m_lat] = 1'b1;
        end
        m_busy = (m_lat >= 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("model_strb", {28'd0, strb}, {28'd0, m_strb});
        check("model_busy", {31'd0, busy}, {31'd0, m_busy});
        check("onehot", {31'd0, $onehot0(strb)}, 32'd1);
    endtask

    task automatic idle(input int n);
        keys = '0;
        repeat (n) tick();
    endtask

    typedef struct {
        logic       en;
        logic [3:0] k;
        logic [3:0] exp_s;
        logic       exp_b;
    } vec_t;

    vec_t tap_tbl[7];
    int   ev[$];
    int   exp_u[7];
    int   dut_cnt, mdl_cnt;

    initial begin
        enable = 1'b1;
        keys   = '0;
        model_reset();

        // Reset: outputs low at once, and held low across edges with a key down
        #1 RST = 1'b0;
        #1;
        check("reset_strb", {28'd0, strb}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        keys = 4'b0001;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_strb", {28'd0, strb}, 32'd0);
        check("reset_hold_busy", {31'd0, busy}, 32'd0);
        keys = '0;
        #2 RST = 1'b1;
        model_reset();

        // Single tap: key_l high for 3 cycles
        tap_tbl[0] = '{1'b1, 4'b0001, 4'b0000, 1'b0};
        tap_tbl[1] = '{1'b1, 4'b0001, 4'b0000, 1'b0};
        tap_tbl[2] = '{1'b1, 4'b0001, 4'b0001, 1'b1};
        tap_tbl[3] = '{1'b1, 4'b0000, 4'b0000, 1'b1};
        tap_tbl[4] = '{1'b1, 4'b0000, 4'b0000, 1'b1};
        tap_tbl[5] = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        tap_tbl[6] = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        for (int i = 0; i < 7; i++) begin
            enable = tap_tbl[i].en;
            keys   = tap_tbl[i].k;
            tick();
            check("tap_strb", {28'd0, strb}, {28'd0, tap_tbl[i].exp_s});
            check("tap_busy", {31'd0, busy}, {31'd0, tap_tbl[i].exp_b});
        end
        idle(4);

        // Hold key_u for 30 cycles
        exp_u = '{2, 10, 14, 18, 22, 26, 30};
        ev.delete();
        for (int e = 0; e < 40; e++) begin
            keys = (e < 30) ? 4'b0100 : 4'b0000;
            tick();
            if (U) ev.push_back(e);
        end
        check("hold_u_count", ev.size(), 7);
        for (int k = 0; k < 7; k++)
            check("hold_u_edge", (k < ev.size()) ? ev[k] : -1, exp_u[k]);
        check("hold_u_busy_end", {31'd0, busy}, 32'd0);
        idle(4);

        // Priority: R and D together, then R released
        for (int e = 0; e <= 40; e++) begin
            logic xr, xd, xb;
            keys = (e < 20) ? 4'b1010 : 4'b1000;
            tick();
            xr = (e == 2 || e == 10 || e == 14 || e == 18);
            xd = (e == 23 || e == 31 || e == 35 || e == 39);
            xb = (e >= 2 && e <= 21) || (e >= 23);
            check("prio_strb", {28'd0, strb}, {28'd0, xd, 1'b0, xr, 1'b0});
            check("prio_busy", {31'd0, busy}, {31'd0, xb});
        end
        idle(6);

        // Enable gating
        enable = 1'b0;
        keys   = 4'b0001;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("en_off_strb", {28'd0, strb}, 32'd0);
            check("en_off_busy", {31'd0, busy}, 32'd0);
        end
        enable = 1'b1;
        for (int e = 0; e <= 18; e++) begin
            logic xl;
            tick();
            xl = (e == 0 || e == 8 || e == 12 || e == 16);
            check("en_on_strb", {28'd0, strb}, {31'd0, xl});
            check("en_on_busy", {31'd0, busy}, 32'd1);
        end
        enable = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("en_drop_strb", {28'd0, strb}, 32'd0);
            check("en_drop_busy", {31'd0, busy}, 32'd0);
        end
        keys = '0;
        repeat (3) tick();
        enable = 1'b1;
        idle(4);

        // Async reset while in REPEAT, right after a strobe
        keys = 4'b0001;
        for (int e = 0; e <= 14; e++) begin
            logic xl;
            tick();
            xl = (e == 2 || e == 10 || e == 14);
            check("pre_rst_strb", {28'd0, strb}, {31'd0, xl});
        end
        #2 RST = 1'b0;
        #1;
        check("async_rst_strb", {28'd0, strb}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        #2 RST = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            logic xl;
            tick();
            xl = (e == 2 || e == 10);
            check("post_rst_strb", {28'd0, strb}, {31'd0, xl});
            check("post_rst_busy", {31'd0, busy}, {31'd0, (e >= 2)});
        end
        idle(6);

        // Random sweep
        dut_cnt = 0;
        mdl_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) keys = 4'($urandom);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            tick();
            dut_cnt += $countones(strb);
            mdl_cnt += $countones(m_strb);
        end
        check("rand_count", dut_cnt, mdl_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
